// File: rtl/fir_batch_ctrl_pkg.sv
// rtl/fir_batch_ctrl_pkg.sv - shared sample width, state encoding and sizing helper
package fir_batch_ctrl_pkg;

  localparam int N = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } fir_state_e;

  // Counter/address width that stays at least one bit for tiny moduli.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fir_batch_ctrl_mod_counter.sv
// rtl/fir_batch_ctrl_mod_counter.sv - modulo-MOD up counter with wrap strobe
module mod_counter #(
  parameter int MOD = 2,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step and fold back to zero after MOD-1.
  always_comb begin
    count_d = count_q;
    wrap    = enable && !clear && (count_q == LAST);
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fir_batch_ctrl.sv
// rtl/fir_batch_ctrl.sv - sample buffer write/fill sequencing and decimated calc triggering
module fir_batch_ctrl
  import fir_batch_ctrl_pkg::*;
#(
  parameter  int Lookahead = 220,
  parameter  int Lookback  = 220,
  parameter  int OSR       = 1,
  parameter  int PipeDelay = 2,
  localparam int D         = Lookahead + Lookback,
  localparam int AW        = addr_w(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [N-1:0]  in,
  input  logic          out_ready,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [N-1:0]  buf_wdata,
  output logic          calc_en,
  output logic [AW-1:0] split_addr,
  output logic          out_valid,
  output logic [1:0]    state,
  output logic          overrun
);

  localparam logic [AW:0] DEPTH     = (AW + 1)'(D);
  localparam logic [AW:0] SPLIT_OFS = (AW + 1)'(D - (Lookahead - 1));

  fir_state_e           state_q,      state_d;
  logic                 buf_we_q,     buf_we_d;
  logic [AW-1:0]        buf_waddr_q,  buf_waddr_d;
  logic [N-1:0]         buf_wdata_q,  buf_wdata_d;
  logic                 calc_en_q,    calc_en_d;
  logic [AW-1:0]        split_addr_q, split_addr_d;
  logic [PipeDelay-1:0] vpipe_q,      vpipe_d;
  logic                 pending_q,    pending_d;
  logic                 overrun_q,    overrun_d;

  logic                 accept;
  logic                 osr_en;
  logic [AW-1:0]        wptr;
  logic                 wptr_wrap;
  logic                 osr_wrap;
  logic [AW:0]          split_sum;
  logic [addr_w(OSR)-1:0] osr_count_unused;

  // A clear in the same cycle as a sample discards the sample.
  assign accept = in_valid && !clr;
  assign osr_en = accept && (state_q == ST_RUN);

  // Write pointer. It starts at zero whenever filling starts, so it also serves
  // as the fill count: its first wrap marks the D-th sample.
  mod_counter #(.MOD(D), .W(AW)) u_wptr (
    .clk    (clk),
    .rst_n  (rst),
    .enable (accept),
    .clear  (clr),
    .count  (wptr),
    .wrap   (wptr_wrap)
  );

  // Decimation counter, stepped only by samples accepted while running.
  mod_counter #(.MOD(OSR), .W(addr_w(OSR))) u_osr (
    .clk    (clk),
    .rst_n  (rst),
    .enable (osr_en),
    .clear  (clr),
    .count  (osr_count_unused),
    .wrap   (osr_wrap)
  );

  // Oldest lookahead sample relative to the address being written now.
  assign split_sum = {1'b0, wptr} + SPLIT_OFS;

  // Next-state, write strobe, calc trigger, valid pipeline and result tracking.
  always_comb begin
    state_d      = state_q;
    buf_we_d     = accept;
    buf_waddr_d  = accept ? wptr : buf_waddr_q;
    buf_wdata_d  = accept ? in   : buf_wdata_q;
    calc_en_d    = 1'b0;
    split_addr_d = split_addr_q;
    vpipe_d      = vpipe_q << 1;
    vpipe_d[0]   = calc_en_q;
    pending_d    = (pending_q || out_valid) && !out_ready;
    overrun_d    = overrun_q || (out_valid && pending_q);

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (accept && wptr_wrap) begin
          state_d   = ST_RUN;
          calc_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (osr_wrap) calc_en_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (calc_en_d) begin
      split_addr_d = AW'((split_sum >= DEPTH) ? split_sum - DEPTH : split_sum);
    end

    if (clr) begin
      state_d      = ST_IDLE;
      buf_waddr_d  = '0;
      calc_en_d    = 1'b0;
      split_addr_d = '0;
      vpipe_d      = '0;
      pending_d    = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  // Control registers; reset drops everything to idle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      buf_we_q     <= 1'b0;
      buf_waddr_q  <= '0;
      buf_wdata_q  <= '0;
      calc_en_q    <= 1'b0;
      split_addr_q <= '0;
      vpipe_q      <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_we_q     <= buf_we_d;
      buf_waddr_q  <= buf_waddr_d;
      buf_wdata_q  <= buf_wdata_d;
      calc_en_q    <= calc_en_d;
      split_addr_q <= split_addr_d;
      vpipe_q      <= vpipe_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
    end
  end

  assign buf_we     = buf_we_q;
  assign buf_waddr  = buf_waddr_q;
  assign buf_wdata  = buf_wdata_q;
  assign calc_en    = calc_en_q;
  assign split_addr = split_addr_q;
  assign out_valid  = vpipe_q[PipeDelay-1];
  assign state      = state_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_batch_ctrl.sv
// tb/tb_fir_batch_ctrl.sv - scoreboard bench for fir_batch_ctrl
module tb_fir_batch_ctrl;
  import fir_batch_ctrl_pkg::*;

  localparam int LA  = 4;
  localparam int LB  = 4;
  localparam int OSRP = 2;
  localparam int PD  = 2;
  localparam int D   = LA + LB;
  localparam int AW  = 3;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_s = '0;
  logic          out_ready = 1'b1;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [N-1:0]  buf_wdata;
  logic          calc_en;
  logic [AW-1:0] split_addr;
  logic          out_valid;
  logic [1:0]    state;
  logic          overrun;

  fir_batch_ctrl #(
    .Lookahead (LA),
    .Lookback  (LB),
    .OSR       (OSRP),
    .PipeDelay (PD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in         (in_s),
    .out_ready  (out_ready),
    .buf_we     (buf_we),
    .buf_waddr  (buf_waddr),
    .buf_wdata  (buf_wdata),
    .calc_en    (calc_en),
    .split_addr (split_addr),
    .out_valid  (out_valid),
    .state      (state),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  ev_t wq[$];
  ev_t cq[$];
  int  ovq[$];

  int  m_state = 0, m_ptr = 0, m_fill = 0, m_osr = 0;
  bit  m_pend = 0, m_ovr = 0, m_pend_n = 0, m_ovr_n = 0;
  int  prev_calc = 0;
  bit  gap_mode = 0;
  int  ov_seen = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_fill = 0; m_osr = 0;
    m_pend = 0; m_ovr = 0; m_pend_n = 0; m_ovr_n = 0;
    wq.delete(); cq.delete(); ovq.delete();
  endtask

  // Reference behaviour at a rising edge, given the inputs that were applied.
  task automatic model_edge(input bit v, input int d, input bit c);
    bit  calc;
    ev_t e;
    if (c) begin
      model_reset();
      return;
    end
    m_pend = m_pend_n;
    m_ovr  = m_ovr_n;
    if (!v) return;
    calc = 0;
    e.cyc = cyc; e.a = m_ptr; e.b = d % (1 << N);
    wq.push_back(e);
    if (m_state != 2) begin
      m_fill++;
      if (m_fill == D) begin
        m_state = 2;
        calc = 1;
      end else begin
        m_state = 1;
      end
    end else begin
      m_osr++;
      if (m_osr == OSRP) begin
        m_osr = 0;
        calc = 1;
      end
    end
    if (calc) begin
      e.cyc = cyc; e.a = (m_ptr - (LA - 1) + D) % D; e.b = 0;
      cq.push_back(e);
      ovq.push_back(cyc + PD);
    end
    m_ptr = (m_ptr + 1) % D;
  endtask

  // Compare what the DUT shows this cycle against the scoreboard.
  task automatic monitor();
    ev_t e;
    int  oc;
    bit  exp_ov;
    while (wq.size() > 0 && wq[0].cyc < cyc) begin
      e = wq.pop_front();
      chk("we_missing", cyc, e.cyc);
    end
    while (cq.size() > 0 && cq[0].cyc < cyc) begin
      e = cq.pop_front();
      chk("calc_missing", cyc, e.cyc);
    end
    while (ovq.size() > 0 && ovq[0] < cyc) begin
      oc = ovq.pop_front();
      chk("ov_missing", cyc, oc);
    end
    exp_ov = (ovq.size() > 0 && ovq[0] == cyc);
    if (buf_we === 1'b1) begin
      if (wq.size() == 0) chk("we_unexpected", 1, 0);
      else begin
        e = wq.pop_front();
        chk("we_cycle", cyc, e.cyc);
        chk("waddr", buf_waddr, e.a);
        chk("wdata", buf_wdata, e.b);
      end
    end
    if (calc_en === 1'b1) begin
      if (cq.size() == 0) chk("calc_unexpected", 1, 0);
      else begin
        e = cq.pop_front();
        chk("calc_cycle", cyc, e.cyc);
        chk("split_addr", split_addr, e.a);
      end
      if (gap_mode && prev_calc > 0) chk("alt_calc_gap", cyc - prev_calc, 4);
      prev_calc = cyc;
    end
    if (out_valid === 1'b1) begin
      ov_seen++;
      if (ovq.size() == 0) chk("ov_unexpected", 1, 0);
      else begin
        oc = ovq.pop_front();
        chk("ov_cycle", cyc, oc);
      end
    end
    chk("state", state, m_state);
    chk("overrun", overrun, m_ovr);
    m_pend_n = (m_pend || exp_ov) && !out_ready;
    m_ovr_n  = m_ovr || (exp_ov && m_pend);
  endtask

  task automatic tick(input bit v, input int d, input bit c);
    in_valid = v;
    in_s     = N'(d);
    clr      = c;
    @(posedge clk);
    cyc++;
    model_edge(v, d, c);
    @(negedge clk);
    monitor();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, buf_we, 0);
    chk({tag, "_waddr"}, buf_waddr, 0);
    chk({tag, "_wdata"}, buf_wdata, 0);
    chk({tag, "_calc"}, calc_en, 0);
    chk({tag, "_split"}, split_addr, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  // Asynchronous reset pulse between edges.
  task automatic pulse_reset();
    #1 rst = 1'b0;
    #1 chk_all_zero("rst_mid");
    model_reset();
    #1 rst = 1'b1;
  endtask

  initial begin
    #2 chk_all_zero("rst_init");
    #1 rst = 1'b1;

    // Twelve back-to-back samples, including the pointer wrap.
    for (int i = 1; i <= 12; i++) begin
      tick(1, i, 0);
      if (i == 7) chk("s7_no_calc", calc_en, 0);
      if (i == 8) begin
        chk("s8_calc", calc_en, 1);
        chk("s8_split", split_addr, 4);
        chk("s8_state_run", state, 2);
      end
      if (i == 9) chk("s9_waddr_wrap", buf_waddr, 0);
      if (i == 10) chk("s10_split", split_addr, 6);
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 0);

    // Alternating valid: counters hold on the gaps.
    tick(0, 0, 1);
    gap_mode = 1;
    prev_calc = 0;
    for (int i = 0; i < 32; i++) tick((i % 2) == 0, i + 3, 0);
    gap_mode = 0;
    for (int i = 0; i < 4; i++) tick(0, 0, 0);

    // Clear collides with sample 10: sample dropped, queued results cancelled.
    tick(0, 0, 1);
    for (int i = 1; i <= 9; i++) tick(1, i * 3, 0);
    tick(1, 5, 1);
    chk("clr_we", buf_we, 0);
    chk("clr_state", state, 0);
    chk("clr_waddr", buf_waddr, 0);
    ov_seen = 0;
    for (int i = 0; i < 5; i++) tick(0, 0, 0);
    chk("clr_no_ov", ov_seen, 0);

    // Downstream stalled across several results.
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) tick(1, i + 1, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0);
    chk("overrun_set", overrun, 1);
    tick(0, 0, 1);
    chk("overrun_cleared", overrun, 0);
    out_ready = 1'b1;

    // Reset in the middle of filling: a full refill is needed.
    for (int i = 1; i <= 5; i++) tick(1, i, 0);
    pulse_reset();
    for (int i = 1; i <= 8; i++) begin
      tick(1, i + 7, 0);
      if (i == 1) chk("refill_first_addr", buf_waddr, 0);
      if (i == 7) chk("refill_s7_no_calc", calc_en, 0);
      if (i == 8) chk("refill_s8_calc", calc_en, 1);
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 0);

    chk("wq_left", wq.size(), 0);
    chk("cq_left", cq.size(), 0);
    chk("ovq_left", ovq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_batch_ctrl.md
FIR_BATCH_CTRL -- requirements
Module: fir_batch_ctrl

Interface
REQ-001 The block SHALL have parameter Lookahead, default 220: number of newest samples in the lookahead window.
REQ-002 The block SHALL have parameter Lookback, default 220: number of samples preceding the lookahead window.
REQ-003 The block SHALL have parameter OSR, default 1: accepted samples per computed result.
REQ-004 The block SHALL have parameter PipeDelay, default 2: datapath latency in cycles from calc_en to result.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous restart.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the in sample is valid this cycle.
REQ-009 The block SHALL have port in, input, N bits: control-bit sample.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port buf_we, output, 1 bit: sample-buffer write enable.
REQ-012 The block SHALL have port buf_waddr, output, AW bits: buffer write address, AW = $clog2(Lookahead+Lookback).
REQ-013 The block SHALL have port buf_wdata, output, N bits: buffer write data.
REQ-014 The block SHALL have port calc_en, output, 1 bit: start datapath computation.
REQ-015 The block SHALL have port split_addr, output, AW bits: address of the oldest lookahead sample.
REQ-016 The block SHALL have port out_valid, output, 1 bit: datapath result valid.
REQ-017 The block SHALL have port state, output, 2 bits: current state.
REQ-018 The block SHALL have port overrun, output, 1 bit: sticky lost-result flag.

Function
REQ-019 Buffer depth D SHALL be Lookahead+Lookback; buf_waddr SHALL increment modulo D, wrapping from D-1 to 0.
REQ-020 States SHALL be IDLE=0, FILL=1, RUN=2; IDLE->FILL on the first accepted in_valid, FILL->RUN on the accepted sample that brings the fill count to D, and RUN holds until clr or reset.
REQ-021 Each accepted sample SHALL produce one registered cycle with buf_we=1, buf_wdata=in and buf_waddr equal to the current pointer; the pointer SHALL advance after the write.
REQ-022 The OSR counter SHALL run 0..OSR-1, SHALL advance only on samples accepted in RUN, and SHALL hold when in_valid=0.
REQ-023 calc_en SHALL pulse for one cycle in the cycle after the D-th accepted sample and, thereafter, after every OSR-th accepted sample.
REQ-024 Together with each calc_en, split_addr SHALL equal (last written address − (Lookahead−1)) mod D.
REQ-025 out_valid SHALL pulse exactly PipeDelay cycles after each calc_en, implemented as a PipeDelay-deep valid shift register.
REQ-026 A result SHALL be pending from its out_valid until a cycle with out_ready=1.
REQ-027 An out_valid arriving while a result is still pending SHALL set overrun, and overrun SHALL stay set until clr or reset.
REQ-028 clr=1 SHALL return the block to IDLE with pointer, fill count, OSR counter, pending flag, valid pipeline and overrun cleared.
REQ-029 When clr=1 and in_valid=1 occur in the same cycle, clr SHALL win and the sample SHALL be discarded (buf_we=0).
REQ-030 All counters SHALL be sized so that Lookahead=Lookback=1 (D=2) and OSR=1 operate correctly.

Reset
REQ-031 rst=0 SHALL asynchronously force state=IDLE and all outputs, counters and the valid pipeline to 0, including mid-FILL or mid-RUN.
REQ-032 Reset release SHALL take effect on the next rising edge of clk, and the first sample SHALL be accepted on that edge.

Structure
REQ-033 N (sample width) and the state typedef SHALL live in the shared coefficients/utility package, not locally.
REQ-034 A single sub-module mod_counter (parameter MOD; ports enable, clear, count and wrap) SHALL be instantiated for the write pointer and for the OSR counter.
REQ-035 There SHALL be no datapath arithmetic in this block; it is control only.

Verification (Lookahead=4, Lookback=4, OSR=2, PipeDelay=2, D=8)
REQ-036 Scenario: 12 consecutive samples -> calc_en after samples 8, 10 and 12; out_valid 2 cycles after each; state=RUN after sample 8.
REQ-037 Scenario: wrap-around -> sample 9 written at address 0; the calc after sample 8 gives split_addr=4, and the calc after sample 10 gives split_addr=6.
REQ-038 Scenario: in_valid alternating 1/0 -> calc_en spacing of 4 cycles, with counters holding on gaps.
REQ-039 Scenario: clr asserted with in_valid at sample 10 -> buf_we=0, state=IDLE, buf_waddr=0, and no out_valid for pending calcs.
REQ-040 Scenario: out_ready held 0 across two out_valid pulses -> overrun=1 from the second pulse, holding until clr.
REQ-041 Scenario: rst pulsed low mid-FILL at sample 5 -> all outputs 0 immediately; refill requires 8 new samples before calc_en.
